pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Owns the fetch-stage program counter and sequences instruction-memory fetches for the 5-stage MIPS pipeline. Each cycle it picks the next PC from four sources: exception vector, `eret` return (EPC), D-stage branch/jump redirect (computed by the next-PC adder), or sequential PC+4. It drives an instruction-memory request/grant handshake and buffers a redirect that arrives while a fetch is in flight. It flags instruction-fetch address errors for the CP0 block.

## Interface
- `RESET_PC`, 32'h0000_3000, PC loaded on reset
- `EXC_VECTOR`, 32'h0000_4180, exception handler entry
- `IM_BASE`, 32'h0000_3000, lowest legal fetch address
- `IM_LIMIT`, 32'h0000_6FFC, highest legal fetch address
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall_i`  in  1  hazard-unit stall; F/D must not accept a new instruction
- `exc_req_i`  in  1  CP0 exception taken this cycle
- `eret_i`  in  1  `eret` in M stage, return to `epc_i`
- `epc_i`  in  32  CP0 EPC
- `br_redirect_i`  in  1  D-stage taken branch / `j` / `jal` / `jr`
- `br_target_i`  in  32  redirect target from the next-PC adder
- `imem_req_o`  out  1  fetch request
- `imem_addr_o`  out  32  fetch address; stable while `imem_req_o` is high and `imem_gnt_i` is low
- `imem_gnt_i`  in  1  fetch completes this cycle; instruction data valid this cycle
- `if_valid_o`  out  1  returned instruction is to be written into F/D
- `pc_f_o`  out  32  PC of the instruction reported by `if_valid_o`
- `adel_o`  out  1  fetch address error: misaligned address, or address outside [IM_BASE, IM_LIMIT]

## Operation
- States:
  - RST: one cycle after reset release, with `imem_req_o`=0.
  - REQ: request outstanding.
  - ERR: the PC is illegal. No request is issued. `adel_o`=1 until a redirect arrives.
- Transitions:
  - RST→REQ unconditionally.
  - REQ→ERR when the PC loaded next is illegal.
  - ERR→REQ on `exc_req_i` (load EXC_VECTOR).
- Next-PC priority, highest first:
  1. `exc_req_i` → EXC_VECTOR
  2. `eret_i` → `epc_i`
  3. `br_redirect_i` → `br_target_i`
  4. PC+4
  Arithmetic is modulo 2^32. Wrap from 32'hFFFF_FFFC is legal arithmetic but fails the range check, so the block goes to ERR.
- Redirect in REQ with `imem_gnt_i`=1: the PC loads the target at the clock edge. The granted instruction is squashed (`if_valid_o`=0) for exception and `eret`. For `br_redirect_i` the granted instruction is the delay slot and is kept.
- Redirect in REQ with `imem_gnt_i`=0:
  - The address must not change, so the target is latched in a one-entry pending buffer (`pend_v`, `pend_pc`, `pend_kind`).
  - A later higher-priority redirect overwrites the pending entry. A lower-priority one is dropped.
  - On grant, the PC loads `pend_pc` and `pend_v` clears. Squash rules are the same as above.
- Stall: the PC advances only on (`imem_gnt_i` & ~`stall_i`) or on a redirect. If grant and stall coincide, `if_valid_o`=0 and the PC holds, so the same address is refetched next cycle.
- Exception while stalled: the exception wins and the PC loads EXC_VECTOR regardless of `stall_i`.
- `if_valid_o` = `imem_gnt_i` & ~`stall_i` & ~squash & state==REQ.

## Timing
- Reset values:
  - PC = RESET_PC
  - `imem_req_o`=0, `imem_addr_o`=RESET_PC
  - `if_valid_o`=0, `pc_f_o`=RESET_PC, `adel_o`=0
  - `pend_v`=0, state RST
- First request is asserted in the second cycle after reset deasserts.
- With zero-wait memory (`imem_gnt_i` tied high), throughput is one fetch per cycle. A redirect seen in cycle n appears on `imem_addr_o` in cycle n+1.
- `if_valid_o`, `pc_f_o` and `adel_o` are combinational from state and inputs in the grant cycle. The PC, state and pending buffer are registered.
- Reset asserted mid-fetch: all state returns to reset values immediately. The outstanding grant is ignored.

## Structure
- Shared package `mips_pkg`:
  - constants RESET_PC, EXC_VECTOR, IM_BASE, IM_LIMIT
  - state enum {RST, REQ, ERR}
  - redirect-kind enum {NONE, BR, ERET, EXC}
- One sub-module, `pc_redirect_buf`, holds the pending redirect entry and the priority overwrite logic.
- The top level holds the FSM, the PC register and the range check.

## Test plan
- Reset, then `imem_gnt_i`=1 continuously → `imem_addr_o` sequence 0x3000, 0x3004, 0x3008, with `if_valid_o`=1 from the first grant.
- `br_redirect_i`=1 with target 0x3100 at PC 0x3008 under zero-wait memory → next address 0x3100. The 0x3008 delay-slot instruction keeps `if_valid_o`=1.
- `imem_gnt_i`=0 for 3 cycles with a branch to 0x3200 and then `exc_req_i` during the wait:
  - `imem_addr_o` stays constant during the wait
  - after grant the address is 0x4180 with `if_valid_o`=0
- `stall_i`=1 coinciding with grant at PC 0x3010 → `if_valid_o`=0 and address 0x3010 reissued. Deassert the stall → `if_valid_o`=1 with `pc_f_o`=0x3010.
- `eret_i` with `epc_i`=0x3002 → ERR state and `adel_o`=1 with no request issued. Then `exc_req_i` → fetch resumes at 0x4180.
- Reset asserted while a request is outstanding → all outputs return to reset values in the same cycle. The first post-reset fetch is 0x3000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: address map, FSM states,
// redirect kinds and the fetch-address legality check.
package mips_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
   localparam logic [31:0] IM_BASE    = 32'h0000_3000;
   localparam logic [31:0] IM_LIMIT   = 32'h0000_6FFC;

   typedef enum logic [1:0] {
      RST = 2'd0,
      REQ = 2'd1,
      ERR = 2'd2
   } fetch_state_t;

   // Encoded so that a larger value means a higher redirect priority.
   typedef enum logic [1:0] {
      NONE = 2'd0,
      BR   = 2'd1,
      ERET = 2'd2,
      EXC  = 2'd3
   } redir_kind_t;

   // A fetch address is legal when word aligned and inside instruction memory.
   function automatic logic pc_is_legal(input logic [31:0] pc);
      return (pc[1:0] == 2'b00) && (pc >= IM_BASE) && (pc <= IM_LIMIT);
   endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for a redirect that arrives while a fetch is waiting for
// its grant. Also merges the incoming redirect with the pending one so the
// top level sees a single "winning" redirect each cycle.
module pc_redirect_buf
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        active,
   input  logic        gnt,
   input  logic [1:0]  in_kind,
   input  logic [31:0] in_pc,
   output logic [1:0]  sel_kind,
   output logic [31:0] sel_pc
);

   logic        pend_v;
   logic [1:0]  pend_kind;
   logic [31:0] pend_pc;
   logic        take_in;

   // Incoming redirect wins over the pending one when its priority is equal
   // or higher; an equal-priority newcomer carries the more recent target.
   always_comb begin
      take_in  = (in_kind != NONE) && (in_kind >= pend_kind);
      sel_kind = pend_kind;
      sel_pc   = pend_pc;
      if (take_in) begin
         sel_kind = in_kind;
         sel_pc   = in_pc;
      end
   end

   // Pending entry: emptied on grant (target consumed) or when not fetching,
   // otherwise holds the winning redirect while the address must stay put.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_v    <= 1'b0;
         pend_kind <= NONE;
         pend_pc   <= RESET_PC;
      end else if (!active || gnt) begin
         pend_v    <= 1'b0;
         pend_kind <= NONE;
      end else if (sel_kind != NONE) begin
         pend_v    <= 1'b1;
         pend_kind <= sel_kind;
         pend_pc   <= sel_pc;
      end
   end

   // pend_kind is NONE exactly when the entry is empty; pend_v is kept as an
   // explicit flag for readability in waveforms.
   logic unused_pend_v;
   assign unused_pend_v = pend_v;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC owner: selects the next PC (exception, eret, branch, PC+4),
// drives the instruction-memory request/grant handshake and flags illegal
// fetch addresses to CP0.
module pc_fetch_sequencer
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        exc_req_i,
   input  logic        eret_i,
   input  logic [31:0] epc_i,
   input  logic        br_redirect_i,
   input  logic [31:0] br_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   output logic        if_valid_o,
   output logic [31:0] pc_f_o,
   output logic        adel_o
);

   fetch_state_t state_reg;
   logic [31:0]  pc_reg;
   logic [31:0]  pc_next;
   redir_kind_t  in_kind;
   logic [31:0]  in_pc;
   logic [1:0]   sel_kind;
   logic [31:0]  sel_pc;
   logic         squash;

   // Collapse the three redirect inputs into one prioritised request.
   always_comb begin
      in_kind = NONE;
      in_pc   = pc_reg;
      if (exc_req_i) begin
         in_kind = EXC;
         in_pc   = EXC_VECTOR;
      end else if (eret_i) begin
         in_kind = ERET;
         in_pc   = epc_i;
      end else if (br_redirect_i) begin
         in_kind = BR;
         in_pc   = br_target_i;
      end
   end

   pc_redirect_buf u_redirect_buf (
      .clk      (clk),
      .reset    (reset),
      .active   (state_reg == REQ),
      .gnt      (imem_gnt_i),
      .in_kind  (in_kind),
      .in_pc    (in_pc),
      .sel_kind (sel_kind),
      .sel_pc   (sel_pc)
   );

   // Next PC while fetching: the address only moves on a grant, to the
   // redirect target if any, else PC+4 unless the decode stage is stalled.
   always_comb begin
      squash  = imem_gnt_i && ((sel_kind == EXC) || (sel_kind == ERET));
      pc_next = pc_reg;
      if (imem_gnt_i) begin
         if (sel_kind != NONE) begin
            pc_next = sel_pc;
         end else if (!stall_i) begin
            pc_next = pc_reg + 32'd4;
         end
      end
   end

   // Fetch FSM and PC register; an illegal next PC parks the block in ERR
   // until CP0 takes the address-error exception.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= RST;
         pc_reg    <= RESET_PC;
      end else begin
         case (state_reg)
            RST: begin
               state_reg <= REQ;
            end
            REQ: begin
               pc_reg    <= pc_next;
               state_reg <= pc_is_legal(pc_next) ? REQ : ERR;
            end
            ERR: begin
               if (exc_req_i) begin
                  pc_reg    <= EXC_VECTOR;
                  state_reg <= REQ;
               end
            end
            default: begin
               state_reg <= RST;
            end
         endcase
      end
   end

   assign imem_req_o  = (state_reg == REQ);
   assign imem_addr_o = pc_reg;
   assign pc_f_o      = pc_reg;
   assign adel_o      = (state_reg == ERR);
   assign if_valid_o  = imem_gnt_i && !stall_i && !squash && (state_reg == REQ);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed walk through the main scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a behavioural model of the fetch rules.
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall_i = 1'b0;
   logic        exc_req_i = 1'b0;
   logic        eret_i = 1'b0;
   logic [31:0] epc_i = 32'h0;
   logic        br_redirect_i = 1'b0;
   logic [31:0] br_target_i = 32'h0;
   logic        imem_gnt_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        if_valid_o;
   logic [31:0] pc_f_o;
   logic        adel_o;

   int total = 0;
   int bad = 0;

   pc_fetch_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .exc_req_i     (exc_req_i),
      .eret_i        (eret_i),
      .epc_i         (epc_i),
      .br_redirect_i (br_redirect_i),
      .br_target_i   (br_target_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .if_valid_o    (if_valid_o),
      .pc_f_o        (pc_f_o),
      .adel_o        (adel_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit legal(input logic [31:0] a);
      return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFC);
   endfunction

   // ---------------- behavioural model ----------------
   // mode: 0 = just out of reset, 1 = fetching, 2 = faulted on illegal PC
   // pending redirect kept as (priority, target); priority 0 = empty
   logic [31:0] m_pc, n_pc, m_ptgt, n_ptgt, itgt, wtgt;
   int          m_mode, n_mode, m_pprio, n_pprio, iprio, wprio;
   logic        e_valid;

   always @(negedge clk) begin
      if (!reset) begin
         chk("rst.req",   32'(imem_req_o), 32'd0);
         chk("rst.addr",  imem_addr_o, 32'h3000);
         chk("rst.valid", 32'(if_valid_o), 32'd0);
         chk("rst.pcf",   pc_f_o, 32'h3000);
         chk("rst.adel",  32'(adel_o), 32'd0);
         n_pc = 32'h3000; n_mode = 0; n_pprio = 0; n_ptgt = 32'h0;
      end else begin
         iprio = exc_req_i ? 3 : eret_i ? 2 : br_redirect_i ? 1 : 0;
         itgt  = exc_req_i ? 32'h4180 : eret_i ? epc_i : br_target_i;
         e_valid = 1'b0;
         n_pc = m_pc; n_mode = m_mode; n_pprio = m_pprio; n_ptgt = m_ptgt;
         if (m_mode == 0) begin
            n_mode = 1;
         end else if (m_mode == 1) begin
            if (iprio != 0 && iprio >= m_pprio) begin
               wprio = iprio; wtgt = itgt;
            end else begin
               wprio = m_pprio; wtgt = m_ptgt;
            end
            if (imem_gnt_i) begin
               e_valid = !stall_i && (wprio < 2);
               n_pprio = 0;
               if (wprio != 0)    n_pc = wtgt;
               else if (!stall_i) n_pc = m_pc + 32'd4;
            end else begin
               n_pprio = wprio; n_ptgt = wtgt;
            end
            n_mode = legal(n_pc) ? 1 : 2;
         end else if (exc_req_i) begin
            n_pc = 32'h4180; n_mode = 1;
         end
         chk("model.req",   32'(imem_req_o), 32'(m_mode == 1));
         chk("model.addr",  imem_addr_o, m_pc);
         chk("model.valid", 32'(if_valid_o), 32'(e_valid));
         chk("model.pcf",   pc_f_o, m_pc);
         chk("model.adel",  32'(adel_o), 32'(m_mode == 2));
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc <= 32'h3000; m_mode <= 0; m_pprio <= 0; m_ptgt <= 32'h0;
      end else begin
         m_pc <= n_pc; m_mode <= n_mode; m_pprio <= n_pprio; m_ptgt <= n_ptgt;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   function automatic logic [31:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       return 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      else if (r == 7) return 32'h6FFC;
      else if (r == 8) return 32'h3000 + 32'($urandom_range(1, 3));
      else             return $urandom;
   endfunction

   initial begin
      imem_gnt_i = 1'b1;
      repeat (2) cyc();
      mid();
      chk("reset.req", 32'(imem_req_o), 32'd0);
      chk("reset.addr", imem_addr_o, 32'h3000);
      cyc(); reset = 1'b1;
      mid();
      chk("rst_state.req", 32'(imem_req_o), 32'd0);
      cyc(); mid();
      chk("seq0.addr", imem_addr_o, 32'h3000);
      chk("seq0.valid", 32'(if_valid_o), 32'd1);
      cyc(); mid();
      chk("seq1.addr", imem_addr_o, 32'h3004);
      cyc(); br_redirect_i = 1'b1; br_target_i = 32'h3100; mid();
      chk("seq2.addr", imem_addr_o, 32'h3008);
      chk("delay_slot.valid", 32'(if_valid_o), 32'd1);
      cyc(); imem_gnt_i = 1'b0; br_target_i = 32'h3200; mid();
      chk("br.addr", imem_addr_o, 32'h3100);
      cyc(); br_redirect_i = 1'b0; exc_req_i = 1'b1; mid();
      chk("wait1.addr", imem_addr_o, 32'h3100);
      cyc(); exc_req_i = 1'b0; mid();
      chk("wait2.addr", imem_addr_o, 32'h3100);
      cyc(); imem_gnt_i = 1'b1; mid();
      chk("exc_gnt.valid", 32'(if_valid_o), 32'd0);
      cyc(); br_redirect_i = 1'b1; br_target_i = 32'h3010; mid();
      chk("vec.addr", imem_addr_o, 32'h4180);
      cyc(); br_redirect_i = 1'b0; stall_i = 1'b1; mid();
      chk("stall.valid", 32'(if_valid_o), 32'd0);
      cyc(); stall_i = 1'b0; mid();
      chk("refetch.addr", imem_addr_o, 32'h3010);
      chk("refetch.valid", 32'(if_valid_o), 32'd1);
      chk("refetch.pcf", pc_f_o, 32'h3010);
      cyc(); eret_i = 1'b1; epc_i = 32'h3002; mid();
      chk("eret.valid", 32'(if_valid_o), 32'd0);
      cyc(); eret_i = 1'b0; mid();
      chk("err.adel", 32'(adel_o), 32'd1);
      chk("err.req", 32'(imem_req_o), 32'd0);
      cyc(); exc_req_i = 1'b1; mid();
      chk("err_hold.adel", 32'(adel_o), 32'd1);
      cyc(); exc_req_i = 1'b0; br_redirect_i = 1'b1; br_target_i = 32'h6FFC; mid();
      chk("resume.addr", imem_addr_o, 32'h4180);
      chk("resume.adel", 32'(adel_o), 32'd0);
      cyc(); br_redirect_i = 1'b0; mid();
      chk("limit.valid", 32'(if_valid_o), 32'd1);
      cyc(); mid();
      chk("overlimit.adel", 32'(adel_o), 32'd1);
      chk("overlimit.pcf", pc_f_o, 32'h7000);
      cyc(); exc_req_i = 1'b1;
      cyc(); exc_req_i = 1'b0; imem_gnt_i = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("midrst.req", 32'(imem_req_o), 32'd0);
      chk("midrst.addr", imem_addr_o, 32'h3000);
      chk("midrst.pcf", pc_f_o, 32'h3000);
      cyc(); reset = 1'b1; imem_gnt_i = 1'b1;
      cyc(); mid();
      chk("postrst.addr", imem_addr_o, 32'h3000);
      chk("postrst.req", 32'(imem_req_o), 32'd1);

      for (int i = 0; i < 3000; i++) begin
         cyc();
         reset         = ($urandom_range(0, 499) != 0);
         imem_gnt_i    = ($urandom_range(0, 9) < 7);
         stall_i       = ($urandom_range(0, 9) < 2);
         exc_req_i     = ($urandom_range(0, 39) == 0);
         eret_i        = ($urandom_range(0, 29) == 0);
         br_redirect_i = ($urandom_range(0, 9) == 0);
         epc_i         = pick_addr();
         br_target_i   = pick_addr();
      end
      cyc();
      reset = 1'b1; exc_req_i = 1'b0; eret_i = 1'b0; br_redirect_i = 1'b0; stall_i = 1'b0;
      repeat (3) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
